// File: rtl/writeback_regfile.sv
// writeback_regfile: MEM/WB writeback mux, 31x32 register file with write-first bypass, commit echo and retire counter
module writeback_regfile (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        mw_valid_i,
    input  logic [31:0] mw_pcsrc_i,
    input  logic [31:0] mw_mem_data_read_i,
    input  logic [31:0] mw_alu_result_i,
    input  logic [4:0]  mw_write_addr_reg_i,
    input  logic [31:0] mw_offset_i,
    input  logic [1:0]  mw_dmem_to_reg_i,
    input  logic        mw_reg_write_i,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o,
    output logic        wb_en_o,
    output logic [4:0]  wb_addr_o,
    output logic [31:0] wb_data_o,
    output logic [31:0] retire_count_o
);
    logic [31:0] regs [1:31];
    logic [31:0] wb_val;
    logic [31:0] retire_cnt;
    logic        commit;
    always_comb begin
        wb_val = mw_dmem_to_reg_i == 2'b00 ? mw_alu_result_i :
                 mw_dmem_to_reg_i == 2'b01 ? mw_mem_data_read_i :
                 mw_dmem_to_reg_i == 2'b10 ? mw_pcsrc_i + 32'd4 :
                                             mw_pcsrc_i + mw_offset_i;
        // gating on reset_i keeps the bypass from leaking data while in reset
        commit = reset_i && mw_valid_i && mw_reg_write_i && (mw_write_addr_reg_i != 5'd0);
    end
    always_comb begin
        rs1_data_o = rs1_addr_i == 5'd0 ? 32'd0 :
                     (commit && mw_write_addr_reg_i == rs1_addr_i) ? wb_val : regs[rs1_addr_i];
        rs2_data_o = rs2_addr_i == 5'd0 ? 32'd0 :
                     (commit && mw_write_addr_reg_i == rs2_addr_i) ? wb_val : regs[rs2_addr_i];
    end
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 1; i < 32; i++) regs[i] <= '0;
            wb_en_o    <= 1'b0;
            wb_addr_o  <= '0;
            wb_data_o  <= '0;
            retire_cnt <= '0;
        end else begin
            wb_en_o <= commit;
            if (commit) begin
                regs[mw_write_addr_reg_i] <= wb_val;
                wb_addr_o <= mw_write_addr_reg_i;
                wb_data_o <= wb_val;
            end
            if (mw_valid_i) retire_cnt <= retire_cnt + 32'd1;
        end
    end
    assign retire_count_o = retire_cnt;
endmodule

// File: tb/tb_writeback_regfile.sv
// tb_writeback_regfile: directed vectors with hand-computed expectations for writeback_regfile
module tb_writeback_regfile;
    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        mw_valid_i = 1'b0;
    logic [31:0] mw_pcsrc_i = '0;
    logic [31:0] mw_mem_data_read_i = '0;
    logic [31:0] mw_alu_result_i = '0;
    logic [4:0]  mw_write_addr_reg_i = '0;
    logic [31:0] mw_offset_i = '0;
    logic [1:0]  mw_dmem_to_reg_i = '0;
    logic        mw_reg_write_i = 1'b0;
    logic [4:0]  rs1_addr_i = '0;
    logic [4:0]  rs2_addr_i = '0;
    logic [31:0] rs1_data_o, rs2_data_o, wb_data_o, retire_count_o;
    logic        wb_en_o;
    logic [4:0]  wb_addr_o;
    int checks = 0;
    int errors = 0;

    writeback_regfile dut (
        .clk_i(clk_i), .reset_i(reset_i), .mw_valid_i(mw_valid_i), .mw_pcsrc_i(mw_pcsrc_i),
        .mw_mem_data_read_i(mw_mem_data_read_i), .mw_alu_result_i(mw_alu_result_i),
        .mw_write_addr_reg_i(mw_write_addr_reg_i), .mw_offset_i(mw_offset_i),
        .mw_dmem_to_reg_i(mw_dmem_to_reg_i), .mw_reg_write_i(mw_reg_write_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rs1_data_o(rs1_data_o),
        .rs2_data_o(rs2_data_o), .wb_en_o(wb_en_o), .wb_addr_o(wb_addr_o),
        .wb_data_o(wb_data_o), .retire_count_o(retire_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] a, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc,
                         input logic [31:0] off);
        mw_valid_i = v;
        mw_reg_write_i = we;
        mw_write_addr_reg_i = a;
        mw_dmem_to_reg_i = sel;
        mw_alu_result_i = alu;
        mw_mem_data_read_i = mem;
        mw_pcsrc_i = pc;
        mw_offset_i = off;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // reads the stored value of a register with no commit pending
    task automatic rd(input string tag, input logic [4:0] idx, input logic [31:0] exp);
        mw_valid_i = 1'b0;
        rs1_addr_i = idx;
        #1;
        chk(tag, rs1_data_o, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tick();
        rs1_addr_i = 5;
        #1;
        chk("rst_wb_en", {31'd0, wb_en_o}, 32'd0);
        chk("rst_wb_addr", {27'd0, wb_addr_o}, 32'd0);
        chk("rst_wb_data", wb_data_o, 32'd0);
        chk("rst_count", retire_count_o, 32'd0);
        chk("rst_rs1", rs1_data_o, 32'd0);
        reset_i = 1'b1;
        // ALU writeback with same-cycle bypass on both ports
        drive(1, 1, 5, 2'b00, 32'h1234_5678, 32'h0, 32'h0, 32'h0);
        rs1_addr_i = 5;
        rs2_addr_i = 5;
        #1;
        chk("byp_rs1", rs1_data_o, 32'h1234_5678);
        chk("byp_rs2", rs2_data_o, 32'h1234_5678);
        tick();
        chk("alu_wb_en", {31'd0, wb_en_o}, 32'd1);
        chk("alu_wb_addr", {27'd0, wb_addr_o}, 32'd5);
        chk("alu_wb_data", wb_data_o, 32'h1234_5678);
        chk("alu_count", retire_count_o, 32'd1);
        rd("alu_x5", 5, 32'h1234_5678);
        // PC+4 wrap, PC+offset wrap, load
        drive(1, 1, 1, 2'b10, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0);
        tick();
        chk("pc4_wb_data", wb_data_o, 32'h0);
        chk("pc4_wb_addr", {27'd0, wb_addr_o}, 32'd1);
        drive(1, 1, 2, 2'b11, 32'h0, 32'h0, 32'h0000_0100, 32'hFFFF_FFF0);
        tick();
        chk("pcoff_wb_data", wb_data_o, 32'h0000_00F0);
        drive(1, 1, 6, 2'b01, 32'h1, 32'hCAFE_F00D, 32'h0, 32'h0);
        tick();
        chk("ld_wb_data", wb_data_o, 32'hCAFE_F00D);
        chk("ld_count", retire_count_o, 32'd4);
        rd("pc4_x1", 1, 32'h0);
        rd("pcoff_x2", 2, 32'h0000_00F0);
        rd("ld_x6", 6, 32'hCAFE_F00D);
        // x0 write retires but never commits
        drive(1, 1, 0, 2'b00, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0);
        rs1_addr_i = 0;
        #1;
        chk("x0_byp", rs1_data_o, 32'h0);
        tick();
        chk("x0_wb_en", {31'd0, wb_en_o}, 32'd0);
        chk("x0_count", retire_count_o, 32'd5);
        chk("x0_hold_addr", {27'd0, wb_addr_o}, 32'd6);
        chk("x0_hold_data", wb_data_o, 32'hCAFE_F00D);
        rd("x0_read", 0, 32'h0);
        // invalid instruction ignored, then valid non-writing one retires
        drive(0, 1, 7, 2'b01, 32'h0, 32'hAAAA_5555, 32'h0, 32'h0);
        rs1_addr_i = 7;
        #1;
        chk("inv_byp", rs1_data_o, 32'h0);
        tick();
        chk("inv_count", retire_count_o, 32'd5);
        chk("inv_wb_en", {31'd0, wb_en_o}, 32'd0);
        drive(1, 0, 7, 2'b01, 32'h0, 32'hAAAA_5555, 32'h0, 32'h0);
        #1;
        chk("nowr_byp", rs1_data_o, 32'h0);
        tick();
        chk("nowr_count", retire_count_o, 32'd6);
        rd("nowr_x7", 7, 32'h0);
        mw_valid_i = 1'b0;
        rs1_addr_i = 5;
        rs2_addr_i = 2;
        #1;
        chk("dual_rs1", rs1_data_o, 32'h1234_5678);
        chk("dual_rs2", rs2_data_o, 32'h0000_00F0);
        // counter wrap via backdoor load
        force dut.retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt;
        #1;
        chk("wrap_pre", retire_count_o, 32'hFFFF_FFFF);
        drive(1, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        chk("wrap_count", retire_count_o, 32'h0);
        // mid-operation reset discards pending commit
        drive(1, 1, 3, 2'b00, 32'h55, 32'h0, 32'h0, 32'h0);
        tick();
        chk("x3_count", retire_count_o, 32'd1);
        drive(1, 1, 4, 2'b00, 32'h77, 32'h0, 32'h0, 32'h0);
        rs1_addr_i = 4;
        #1;
        reset_i = 1'b0;
        #1;
        chk("mrst_rs1", rs1_data_o, 32'h0);
        chk("mrst_wb_en", {31'd0, wb_en_o}, 32'd0);
        chk("mrst_wb_addr", {27'd0, wb_addr_o}, 32'd0);
        chk("mrst_wb_data", wb_data_o, 32'h0);
        chk("mrst_count", retire_count_o, 32'h0);
        tick();
        reset_i = 1'b1;
        rd("mrst_x3", 3, 32'h0);
        rd("mrst_x4", 4, 32'h0);
        drive(1, 1, 4, 2'b00, 32'h99, 32'h0, 32'h0, 32'h0);
        tick();
        chk("post_wb_en", {31'd0, wb_en_o}, 32'd1);
        chk("post_wb_data", wb_data_o, 32'h99);
        chk("post_count", retire_count_o, 32'd1);
        rd("post_x4", 4, 32'h99);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-002 clk_i  input  1  clock; all state updates on the rising edge.
REQ-003 reset_i  input  1  reset, asynchronous, active-low.
REQ-004 mw_valid_i  input  1  MEM/WB stage holds a valid instruction this cycle.
REQ-005 mw_pcsrc_i  input  32  PC of the retiring instruction.
REQ-006 mw_mem_data_read_i  input  32  load data from data memory.
REQ-007 mw_alu_result_i  input  32  ALU result.
REQ-008 mw_write_addr_reg_i  input  5  destination register index.
REQ-009 mw_offset_i  input  32  immediate offset for PC-relative writeback.
REQ-010 mw_dmem_to_reg_i  input  2  writeback source select.
REQ-011 mw_reg_write_i  input  1  destination register write enable.
REQ-012 rs1_addr_i, rs2_addr_i  input  5 each  decode-stage read indices.
REQ-013 rs1_data_o, rs2_data_o  output  32 each  read data.
REQ-014 wb_en_o  output  1  registered: a register was committed last cycle.
REQ-015 wb_addr_o  output  5  registered index of the last commit.
REQ-016 wb_data_o  output  32  registered data of the last commit.
REQ-017 retire_count_o  output  32  count of valid instructions retired.

Function
REQ-018 The writeback value SHALL be selected combinationally from mw_dmem_to_reg_i:
- 00: mw_alu_result_i
- 01: mw_mem_data_read_i
- 10: mw_pcsrc_i + 4
- 11: mw_pcsrc_i + mw_offset_i
- Both additions are modulo 2^32, with carry discarded.
REQ-019 The storage SHALL be 31 writable 32-bit registers (x1..x31); x0 SHALL read 0 always and SHALL never be stored.
REQ-020 A commit SHALL occur on a rising edge only when reset_i=1, mw_valid_i=1, mw_reg_write_i=1 and mw_write_addr_reg_i!=0.
- A commit writes the selected value to the indexed register.
REQ-021 Reads SHALL be combinational.
- If a commit is pending this cycle and its index equals a nonzero read index, that port SHALL return the writeback value (write-first bypass).
- Otherwise the port SHALL return the stored register value.
REQ-022 Both read ports SHALL be independent; the same index on both SHALL return identical data.
REQ-023 wb_en_o, wb_addr_o and wb_data_o SHALL update one cycle after each edge:
- On a commit: wb_en_o=1, with wb_addr_o and wb_data_o set to the committed index and value.
- Otherwise: wb_en_o=0, and wb_addr_o/wb_data_o hold their previous values.
REQ-024 retire_count_o SHALL increment by 1 on every edge with mw_valid_i=1 and reset_i=1, regardless of mw_reg_write_i.
- It wraps from 0xFFFFFFFF to 0.
REQ-025 A write to x0 with mw_valid_i=1 SHALL count as retired, SHALL NOT commit, and SHALL leave wb_en_o=0.
REQ-026 With mw_valid_i=0, all other MEM/WB inputs SHALL be ignored: no commit and no count.
REQ-027 Read latency SHALL be 0 cycles; commit latency SHALL be 1 edge; wb_* latency SHALL be 1 cycle.

Reset
REQ-028 While reset_i=0:
- All 31 registers, wb_en_o, wb_addr_o, wb_data_o and retire_count_o SHALL be 0, asynchronously.
- rs1_data_o and rs2_data_o SHALL read 0, and no commit SHALL occur.
REQ-029 If reset asserts mid-operation, any commit at the same edge SHALL be discarded.
REQ-030 The first rising edge with reset_i=1 SHALL behave as a normal cycle.

Verification
REQ-031 ALU writeback and bypass:
- Stimulus: valid=1, reg_write=1, addr=5, sel=00, alu=0x12345678, rs1_addr=5 in the same cycle.
- Response: rs1_data_o=0x12345678 before the edge; x5=0x12345678 after it; wb_en_o=1, wb_addr_o=5.
REQ-032 PC-relative writeback with wrap:
- Stimulus: sel=10, pcsrc=0xFFFFFFFC, addr=1.
- Response: x1=0x00000000.
- Stimulus: sel=11, pcsrc=0x100, offset=0xFFFFFFF0, addr=2.
- Response: x2=0x000000F0.
REQ-033 x0 protection:
- Stimulus: valid=1, reg_write=1, addr=0, alu=0xDEADBEEF.
- Response: rs1_data_o at index 0 stays 0; wb_en_o=0; retire_count_o increments by 1.
REQ-034 Invalid and non-writing instructions:
- Stimulus: valid=0 with reg_write=1, addr=7, sel=01, mem=0xAAAA5555.
- Response: x7 unchanged; count unchanged.
- Stimulus: then valid=1, reg_write=0.
- Response: count +1, x7 unchanged.
REQ-035 Counter wrap:
- Stimulus: drive retire_count to 0xFFFFFFFF, then one valid cycle.
- Response: retire_count_o=0.
REQ-036 Mid-operation reset:
- Stimulus: after writing x3=0x55, pull reset_i low between edges, coincident with a pending commit to x4.
- Response: x3=0, x4=0, and all outputs 0 immediately.
- Stimulus: release reset_i.
- Response: the next valid commit writes normally.
